vga_colorbar: RTL and testbench
===============================

VGA_COLORBAR -- requirements
Module: vga_colorbar

Interface
REQ-001 Parameters: H_ACTIVE=640, V_ACTIVE=480, BAR_W=80 (pixels per colour bar); defaults fixed as given.
REQ-002 One clock; reset is asynchronous and active-low: sys_clk input 1 (50 MHz system clock, sole clock), sys_rstn input 1 (async active-low reset).
REQ-003 clk_4Hz  input  1  slow animation strobe; sampled as data in sys_clk domain, never used as a clock.
REQ-004 key  input  1  mode pushbutton, asynchronous level.
REQ-005 hsync  output  1  horizontal sync, active-low.
REQ-006 vsync  output  1  vertical sync, active-low.
REQ-007 vga_rgb  output  3  {R,G,B} pixel colour.

Function
REQ-008 Pixel enable pix_en SHALL toggle every sys_clk (25 MHz effective pixel rate); all counters advance only when pix_en=1.
REQ-009 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment when h_cnt wraps and count 0..524, then wrap to 0.
REQ-010 Horizontal: sync 0..95, back porch 96..143, active 144..783, front porch 784..799; hsync=0 iff h_cnt<96.
REQ-011 Vertical: sync 0..1, back porch 2..34, active 35..514, front porch 515..524; vsync=0 iff v_cnt<2.
REQ-012 Active region: x=h_cnt-144 (0..639), y=v_cnt-35 (0..479); vga_rgb=3'b000 outside active region.
REQ-013 Bar index b=x/80 (0..7); displayed colour = (b+offset) mod 8 as 3-bit value (bar 0 at offset 0 = black, bar 7 = white).
REQ-014 key SHALL be synchronised with 2 flip-flops; each synchronised rising edge toggles mode (0=static, 1=scroll); no debounce inside block.
REQ-015 clk_4Hz SHALL be synchronised with 2 flip-flops; each synchronised rising edge while mode=1 increments 3-bit offset, wrapping 7->0.
REQ-016 In mode=0 offset holds its value; switching to mode 0 does not clear offset.
REQ-017 offset and mode changes SHALL be applied only at frame start (h_cnt=0, v_cnt=0) via shadow register, so no frame shows tearing.
REQ-018 hsync, vsync, vga_rgb SHALL be registered; all three derive from the same counter state (aligned, 1 sys_clk latency from counter).
REQ-019 Simultaneous key edge and clk_4Hz edge: mode toggle takes effect first, increment uses new mode in the following strobe.

Reset
REQ-020 sys_rstn=0 SHALL asynchronously clear h_cnt, v_cnt, pix_en, offset, shadow offset, mode, synchroniser flops.
REQ-021 During reset hsync=1, vsync=1, vga_rgb=3'b000.
REQ-022 After release, counting starts at h_cnt=0, v_cnt=0 on the first pix_en; reset mid-frame restarts the frame with no partial-state carry-over.

Structure
REQ-023 Shared package vga_colorbar_pkg SHALL hold H/V sync, porch, active and total constants and BAR_W.
REQ-024 One sub-module vga_timing (pix_en, counters, sync, active flag, x/y); colour/mode logic stays in vga_colorbar.

Verification
REQ-025 Reset release -> hsync low for 96 pixels (192 sys_clk), period 1600 sys_clk (32 us); vsync low for 2 lines (3200 sys_clk), period 840000 sys_clk.
REQ-026 Static mode, line y=0 -> vga_rgb 0 for first 144 pixels, then 0,1,2..7 each for 160 sys_clk, then 0 in front porch.
REQ-027 key 0->1 at 20 ns, clk_4Hz strobes -> after next frame start, first bar shows offset value; offset wraps 7->0 after 8 strobes.
REQ-028 key toggled 1->0->1 at 30 us spacing -> mode toggles only on rising edges; falling edge no effect.
REQ-029 sys_rstn pulsed low mid-line -> outputs immediately hsync=1, vsync=1, rgb=0; timing restarts at count 0.
REQ-030 Vertical blanking rows (v_cnt<35 or >514) -> vga_rgb=0 for entire line.

Source files
------------

// File: rtl/vga_colorbar_pkg.sv
// VGA colour-bar shared definitions: 640x480@60 timing, bar width,
// counter/colour types, display mode and the bar colour helper.
package vga_colorbar_pkg;

  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_TOTAL  =
    H_SYNC + H_BP + H_ACTIVE + H_FP;

  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_TOTAL  =
    V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam int unsigned BAR_W = 80;
  localparam int unsigned CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [2:0]       rgb_t;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_SCROLL = 1'b1
  } mode_e;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic active;
    cnt_t x;
  } tim_t;

  // Colour of the bar under column x, rotated by off (mod 8).
  function automatic rgb_t bar_color(
    input cnt_t x,
    input cnt_t bar_w,
    input rgb_t off
  );
    return rgb_t'(x / bar_w) + off;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel enable, h/v counters, sync levels,
// active flag, x offset. Ports: clk_i, rst_ni, frame_start_o, tim_o.
module vga_timing
  import vga_colorbar_pkg::*;
#(
  parameter int unsigned H_ACT = H_ACTIVE,
  parameter int unsigned V_ACT = V_ACTIVE
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic frame_start_o,
  output tim_t tim_o
);

  localparam cnt_t H_LAST =
    cnt_t'(H_TOTAL - H_ACTIVE + H_ACT - 1);
  localparam cnt_t V_LAST =
    cnt_t'(V_TOTAL - V_ACTIVE + V_ACT - 1);
  localparam cnt_t H_SYN = cnt_t'(H_SYNC);
  localparam cnt_t V_SYN = cnt_t'(V_SYNC);
  localparam cnt_t H_ORG = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t V_ORG = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t H_LEN = cnt_t'(H_ACT);
  localparam cnt_t V_LEN = cnt_t'(V_ACT);

  logic pix_en_q;
  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  cnt_t x, y;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      pix_en_q <= ~pix_en_q;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  // Before the active origin the subtraction wraps to a value far
  // above the active length, so one unsigned compare per axis
  // covers both porches (totals stay below 2**CNT_W).
  assign x = h_q - H_ORG;
  assign y = v_q - V_ORG;

  always_comb begin
    tim_o.hs_n   = (h_q >= H_SYN);
    tim_o.vs_n   = (v_q >= V_SYN);
    tim_o.active = (x < H_LEN) && (y < V_LEN);
    tim_o.x      = x;
  end

  assign frame_start_o =
    pix_en_q && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_colorbar.sv
// 8-bar VGA test pattern, static or scrolling on a 4 Hz strobe.
// Ports: sys_clk, sys_rstn, clk_4Hz, key, hsync, vsync, vga_rgb.
module vga_colorbar #(
  parameter int unsigned H_ACTIVE = vga_colorbar_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = vga_colorbar_pkg::V_ACTIVE,
  parameter int unsigned BAR_W    = vga_colorbar_pkg::BAR_W
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic       clk_4Hz,
  input  logic       key,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] vga_rgb
);

  import vga_colorbar_pkg::*;

  logic [1:0] key_s_q;
  logic [1:0] tick_s_q;
  logic       key_p_q;
  logic       tick_p_q;
  logic       key_rise;
  logic       tick_rise;

  mode_e mode_q, mode_d;
  rgb_t  off_q, off_d;
  rgb_t  shd_q, shd_d;
  rgb_t  rgb_q, rgb_d;
  logic  hs_q, vs_q;

  logic  frame_start;
  tim_t  tim;

  vga_timing #(
    .H_ACT (H_ACTIVE),
    .V_ACT (V_ACTIVE)
  ) u_timing (
    .clk_i         (sys_clk),
    .rst_ni        (sys_rstn),
    .frame_start_o (frame_start),
    .tim_o         (tim)
  );

  assign key_rise  = key_s_q[1]  & ~key_p_q;
  assign tick_rise = tick_s_q[1] & ~tick_p_q;

  always_comb begin
    mode_d = mode_q;
    if (key_rise) begin
      mode_d = (mode_q == MODE_SCROLL) ?
               MODE_STATIC : MODE_SCROLL;
    end
  end

  // A strobe coinciding with a key edge sees the old mode.
  always_comb begin
    off_d = off_q;
    if (tick_rise && (mode_q == MODE_SCROLL)) begin
      off_d = off_q + 3'd1;
    end
  end

  // The displayed offset only moves at frame start.
  assign shd_d = frame_start ? off_q : shd_q;

  assign rgb_d = tim.active ?
    bar_color(tim.x, cnt_t'(BAR_W), shd_q) : '0;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      key_s_q  <= '0;
      tick_s_q <= '0;
      key_p_q  <= 1'b0;
      tick_p_q <= 1'b0;
      mode_q   <= MODE_STATIC;
      off_q    <= '0;
      shd_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      rgb_q    <= '0;
    end else begin
      key_s_q  <= {key_s_q[0], key};
      tick_s_q <= {tick_s_q[0], clk_4Hz};
      key_p_q  <= key_s_q[1];
      tick_p_q <= tick_s_q[1];
      mode_q   <= mode_d;
      off_q    <= off_d;
      shd_q    <= shd_d;
      hs_q     <= tim.hs_n;
      vs_q     <= tim.vs_n;
      rgb_q    <= rgb_d;
    end
  end

  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign vga_rgb = rgb_q;

endmodule

// File: tb/tb_vga_colorbar.sv
// Bench for vga_colorbar: full-size and shrunken instances checked
// every cycle against a raster model; random key/strobe traffic.
module tb_vga_colorbar;

  logic sys_clk  = 1'b0;
  logic sys_rstn = 1'b1;
  logic clk_4Hz  = 1'b0;
  logic key      = 1'b0;

  logic       hs_f, vs_f, hs_s, vs_s;
  logic [2:0] rgb_f, rgb_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  logic       m_mode = 1'b0;
  logic [2:0] m_off  = 3'd0;

  int         fr_f = 0, fr_s = 0;
  logic [2:0] off_f = 3'd0, off_s = 3'd0;

  always #10 sys_clk = ~sys_clk;

  vga_colorbar dut_f (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .clk_4Hz  (clk_4Hz),
    .key      (key),
    .hsync    (hs_f),
    .vsync    (vs_f),
    .vga_rgb  (rgb_f)
  );

  vga_colorbar #(
    .H_ACTIVE (80),
    .V_ACTIVE (2),
    .BAR_W    (10)
  ) dut_s (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .clk_4Hz  (clk_4Hz),
    .key      (key),
    .hsync    (hs_s),
    .vsync    (vs_s),
    .vga_rgb  (rgb_s)
  );

  always @(posedge sys_clk or negedge sys_rstn)
    if (!sys_rstn) cyc <= 0;
    else           cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Expected {hsync,vsync,rgb} after the k-th clock edge since
  // reset release: each pixel spans two clocks, one clock latency.
  function automatic logic [4:0] vga_ref(
    input int k, input int hact, input int vact,
    input int barw, input logic [2:0] off
  );
    int htot, vtot, p, h, v;
    logic [4:0] r;
    htot = 96 + 48 + hact + 16;
    vtot = 2 + 33 + vact + 10;
    p = ((k - 1) / 2) % (htot * vtot);
    h = p % htot;
    v = p / htot;
    r = 5'd0;
    r[4] = (h >= 96);
    r[3] = (v >= 2);
    if (h >= 144 && h < 144 + hact &&
        v >= 35 && v < 35 + vact)
      r[2:0] = 3'((((h - 144) / barw) + off) % 8);
    return r;
  endfunction

  function automatic int frame_no(
    input int k, input int hact, input int vact
  );
    return ((k - 1) / 2) / ((160 + hact) * (45 + vact));
  endfunction

  initial forever begin
    @(negedge sys_clk);
    if (!sys_rstn) begin
      fr_f  = 0;
      off_f = 3'd0;
      chk("rst_f", {27'd0, hs_f, vs_f, rgb_f}, 32'h18);
    end else begin
      if (frame_no(cyc, 640, 480) != fr_f) begin
        fr_f  = frame_no(cyc, 640, 480);
        off_f = m_off;
      end
      chk("pix_f", {27'd0, hs_f, vs_f, rgb_f},
          {27'd0, vga_ref(cyc, 640, 480, 80, off_f)});
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (!sys_rstn) begin
      fr_s  = 0;
      off_s = 3'd0;
      chk("rst_s", {27'd0, hs_s, vs_s, rgb_s}, 32'h18);
    end else begin
      if (frame_no(cyc, 80, 2) != fr_s) begin
        fr_s  = frame_no(cyc, 80, 2);
        off_s = m_off;
      end
      chk("pix_s", {27'd0, hs_s, vs_s, rgb_s},
          {27'd0, vga_ref(cyc, 80, 2, 10, off_s)});
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(posedge sys_clk);
  endtask

  task automatic hold_rand();
    repeat ($urandom_range(4, 10)) @(posedge sys_clk);
  endtask

  task automatic step_key();
    @(posedge sys_clk);
    #2;
    if (!key) m_mode = ~m_mode;
    key = ~key;
    hold_rand();
  endtask

  task automatic strobe(input bit with_key);
    @(posedge sys_clk);
    #2;
    if (m_mode) m_off = m_off + 3'd1;
    if (with_key) begin
      if (!key) m_mode = ~m_mode;
      key = ~key;
    end
    clk_4Hz = 1'b1;
    hold_rand();
    #2 clk_4Hz = 1'b0;
    hold_rand();
  endtask

  task automatic run_events(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       step_key();
        1:       strobe(1'b0);
        default: strobe(1'b1);
      endcase
    end
  endtask

  initial begin
    #1 sys_rstn = 1'b0;
    repeat (2) @(negedge sys_clk);
    #5 sys_rstn = 1'b1;

    wait_cyc(2 * 240 * 38);
    step_key();
    run_events($urandom_range(10, 20));

    wait_cyc(22560 + 2 * 240 * 38);
    run_events($urandom_range(6, 16));
    if (key) step_key();

    wait_cyc(63000 + $urandom_range(0, 400));
    @(posedge sys_clk);
    #3 sys_rstn = 1'b0;
    m_mode = 1'b0;
    m_off  = 3'd0;
    #1;
    chk("async_rst_f", {29'd0, hs_f, vs_f, rgb_f[0]}, 32'h6);
    chk("async_rgb_f", {29'd0, rgb_f}, 32'h0);
    chk("async_rst_s", {29'd0, hs_s, vs_s, rgb_s[0]}, 32'h6);
    chk("async_rgb_s", {29'd0, rgb_s}, 32'h0);
    repeat (3) @(negedge sys_clk);
    #5 sys_rstn = 1'b1;

    wait_cyc(3400);
    @(negedge sys_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not end (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
